// File: rtl/nibble_addsub_seq.sv
// nibble_addsub_seq: 16-bit add/sub computed one carry-lookahead nibble per cycle.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module nibble_addsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum,
  output logic        Z,
  output logic        V,
  output logic        N
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] a_r, b_r, acc, fin, res;
  logic [1:0]  idx;
  logic        c;
  logic [3:0]  an, bn, g, p, s;
  logic [4:0]  cc;
  logic        v_nx;
  assign an = a_r[idx*4 +: 4];
  assign bn = b_r[idx*4 +: 4];
  assign g  = an & bn;
  assign p  = an ^ bn;
  always_comb begin
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
  end
  assign s    = p ^ cc[3:0];
  assign v_nx = cc[3] ^ cc[4];
  assign res  = {s, acc[11:0]};
`ifdef ADDSUB_SAT_EN
  assign fin = v_nx ? (a_r[15] ? 16'h8000 : 16'h7FFF) : res;
`else
  assign fin = res;
`endif
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      RUN: begin
        busy = 1'b1;
        state_nx = (idx == 2'd3) ? DONE : RUN;
      end
      DONE: begin
        done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      a_r   <= 16'h0;
      b_r   <= 16'h0;
      c     <= 1'b0;
      acc   <= 16'h0;
      Sum   <= 16'h0;
      Z     <= 1'b0;
      V     <= 1'b0;
      N     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_r <= A;
        b_r <= sub ? ~B : B;
        c   <= sub;
        idx <= 2'd0;
        acc <= 16'h0;
      end else if (state == RUN) begin
        acc[idx*4 +: 4] <= s;
        c   <= cc[4];
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          Sum <= fin;
          Z   <= (fin == 16'h0);
          V   <= v_nx;
          N   <= fin[15];
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_addsub_seq.sv
// tb_nibble_addsub_seq: directed vector table plus hand-written corner sequences.
module tb_nibble_addsub_seq;
  logic        clk = 0, rst_n = 0, start = 0, sub = 0;
  logic [15:0] A = 0, B = 0;
  logic        ready, busy, done, Z, V, N;
  logic [15:0] Sum;
  int cmp = 0, bad = 0;

  nibble_addsub_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sub(sub),
    .ready(ready), .busy(busy), .done(done), .Sum(Sum), .Z(Z), .V(V), .N(N));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] sum;
    logic        z, v, n;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input vec_t t);
    chk({nm, " Sum"}, Sum, t.sum);
    chk({nm, " Z"}, {15'h0, Z}, {15'h0, t.z});
    chk({nm, " V"}, {15'h0, V}, {15'h0, t.v});
    chk({nm, " N"}, {15'h0, N}, {15'h0, t.n});
  endtask

  // Issue a start at edge 0 and check done is asserted only after edge 4.
  task automatic run_op(input string nm, input vec_t t);
    @(negedge clk);
    chk({nm, " ready"}, {15'h0, ready}, 16'h1);
    A = t.a; B = t.b; sub = t.s; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int k = 1; k <= 4; k++) begin
      chk({nm, " busy"}, {15'h0, busy}, 16'h1);
      A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      if (k < 4) chk({nm, " early done"}, {15'h0, done}, 16'h0);
    end
    chk({nm, " done"}, {15'h0, done}, 16'h1);
    chk_res(nm, t);
    @(posedge clk); #1;
    chk({nm, " ready back"}, {15'h0, ready}, 16'h1);
    chk({nm, " done drop"}, {15'h0, done}, 16'h0);
  endtask

  initial begin
    vec_t h;
    vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1};
`else
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1};
    vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
`endif
    vt[2] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[6] = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vt[7] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};

    #12;
    chk("reset ready", {15'h0, ready}, 16'h1);
    chk("reset busy", {15'h0, busy}, 16'h0);
    chk("reset done", {15'h0, done}, 16'h0);
    h = '{16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    chk_res("reset", h);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vt[i]);

    // Result hold through idle with changing inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
    end
    @(negedge clk);
    chk_res("hold", vt[7]);

    // Start pulsed mid-RUN is ignored
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; sub = 0; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    A = 16'hFFFF; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    chk("ign early done", {15'h0, done}, 16'h0);
    @(posedge clk); #1;
    chk("ign done", {15'h0, done}, 16'h1);
    chk("ign Sum", Sum, 16'h0002);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("ign no 2nd op", {14'h0, done, busy}, 16'h0);
    end

    // Reset during RUN index 2
    @(negedge clk);
    A = 16'h0100; B = 16'h0200; sub = 0; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("rst ready", {15'h0, ready}, 16'h1);
    chk("rst busy", {15'h0, busy}, 16'h0);
    h = '{16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    chk_res("rst", h);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rst no done", {15'h0, done}, 16'h0);
    end
    @(negedge clk); rst_n = 1;
    h = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
    run_op("post rst", h);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
